nibble_burst_tx: RTL

//  Transmit end of the 16-beat nibble-burst link: collects 4-bit samples from a

---
 rtl/nibble_burst_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/nibble_burst_tx.sv
// Nibble-burst link transmitter: packs 128 source nibbles per bank into a
// 16-beat burst, then waits for the core's 128-beat result stream.
module nibble_burst_tx #(
  parameter int BEATS   = 16,
  parameter int RES_LEN = 128,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [3:0]  s_nibble,
  output logic        s_ready,
  output logic        in_valid,
  output logic [31:0] in_data,
  input  logic        out_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam logic [3:0]  LAST_BEAT = 4'(BEATS - 1);
  localparam logic [7:0]  RES_N     = 8'(RES_LEN);
  localparam logic [12:0] TMO_N     = 13'(TIMEOUT);
  localparam logic [1:0]  GAP_L     = 2'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  logic [31:0] r_mem [2][16];
  logic [6:0]  r_fcnt [2];
  logic [1:0]  r_full;
  logic        r_fbank;
  logic        r_sbank;
  state_t      r_state;
  logic [3:0]  r_beat;
  logic [7:0]  r_res;
  logic [12:0] r_tmo;
  logic [1:0]  r_gap;
  logic        r_in_valid;
  logic [31:0] r_in_data;
  logic        r_busy;
  logic        r_tmo_err;
  logic        r_proto_err;

  logic        w_ready;
  logic        w_acc;
  logic [6:0]  w_fcnt;
  logic [7:0]  w_res_nx;
  logic [12:0] w_tmo_nx;

  assign w_fcnt   = r_fcnt[r_fbank];
  assign w_ready  = !r_full[r_fbank];
  assign w_acc    = s_valid && w_ready;
  assign w_res_nx = r_res + {7'd0, out_valid};
  assign w_tmo_nx = r_tmo + 13'd1;

  assign s_ready     = w_ready;
  assign in_valid    = r_in_valid;
  assign in_data     = r_in_data;
  assign busy        = r_busy;
  assign timeout_err = r_tmo_err;
  assign proto_err   = r_proto_err;

  // nibble k lands in beat k[6:3], lane k[2:0]
  always_ff @(posedge clk) begin
    if (w_acc)
      r_mem[r_fbank][w_fcnt[6:3]][{w_fcnt[2:0], 2'b00} +: 4] <= s_nibble;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt[0]   <= '0;
      r_fcnt[1]   <= '0;
      r_full      <= '0;
      r_fbank     <= 1'b0;
      r_sbank     <= 1'b0;
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_res       <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_in_valid  <= 1'b0;
      r_in_data   <= '0;
      r_busy      <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_fcnt[r_fbank] <= w_fcnt + 7'd1;
        if (w_fcnt == 7'd127) begin
          r_full[r_fbank] <= 1'b1;
          r_fbank         <= ~r_fbank;
        end
      end
      if (out_valid && r_state != S_WAIT)
        r_proto_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (r_full[r_sbank]) begin
            r_state    <= S_SEND;
            r_beat     <= '0;
            r_in_valid <= 1'b1;
            r_in_data  <= r_mem[r_sbank][4'd0];
            r_busy     <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_beat == LAST_BEAT) begin
            r_in_valid      <= 1'b0;
            r_in_data       <= '0;
            r_full[r_sbank] <= 1'b0;
            r_sbank         <= ~r_sbank;
            r_state         <= S_WAIT;
            r_res           <= '0;
            r_tmo           <= '0;
          end else begin
            r_beat    <= r_beat + 4'd1;
            r_in_data <= r_mem[r_sbank][r_beat + 4'd1];
          end
        end
        S_WAIT: begin
          r_res <= w_res_nx;
          r_tmo <= w_tmo_nx;
          // completion takes priority over a simultaneous timeout
          if (w_res_nx == RES_N) begin
            r_state <= S_GAP;
            r_gap   <= '0;
          end else if (w_tmo_nx == TMO_N) begin
            r_tmo_err <= 1'b1;
            r_state   <= S_GAP;
            r_gap     <= '0;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_L) begin
            if (r_full[r_sbank]) begin
              r_state    <= S_SEND;
              r_beat     <= '0;
              r_in_valid <= 1'b1;
              r_in_data  <= r_mem[r_sbank][4'd0];
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap <= r_gap + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
